// File: rtl/phy_tx_scheduler.sv
// Round-robin arbiter sharing one 802.11a PHY transmit path between a data and a management source.
// Validates RATE, issues tx_request, streams bits paced by phy_ready, then enforces an inter-frame gap.
module phy_tx_scheduler #(
  parameter int LEN_W         = 12,
  parameter int IFS_CYCLES    = 16,
  parameter int READY_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       rate0,
  input  logic [3:0]       rate1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             data0,
  input  logic             data1,
  output logic             pop0,
  output logic             pop1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic             phy_tx_request,
  output logic [3:0]       phy_rate,
  input  logic             phy_ready,
  output logic             phy_in,
  output logic             phy_run,
  output logic             busy
);

  localparam int CNT_MAX = (READY_TIMEOUT > IFS_CYCLES) ? READY_TIMEOUT : IFS_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    REQ,
    WAIT_RDY,
    STREAM,
    GAP
  } state_t;

  state_t           state;
  logic             sel;
  logic             prio;
  logic [3:0]       rate_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [CW-1:0]    cnt;
  logic             done_q0;
  logic             done_q1;
  logic             win;
  logic             rate_ok;
  logic             stream_go;
  logic             last_bit;

  always_comb begin
    rate_ok = 1'b0;
    case (rate_q)
      4'b1101, 4'b1111, 4'b0101, 4'b0111,
      4'b1001, 4'b1011, 4'b0001, 4'b0011: rate_ok = 1'b1;
      default:                            rate_ok = 1'b0;
    endcase
  end

  // prio names the source favoured when both request; it flips to the loser on every grant
  assign win       = (req0 && req1) ? prio : req1;
  assign stream_go = (state == STREAM) && phy_ready;
  assign last_bit  = stream_go && (bit_cnt == len_q - LEN_W'(1));

  assign phy_run = stream_go;
  assign phy_in  = stream_go & (sel ? data1 : data0);
  assign pop0    = stream_go & ~sel;
  assign pop1    = stream_go & sel;
  assign done0   = done_q0 | (last_bit & ~sel);
  assign done1   = done_q1 | (last_bit & sel);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      sel            <= 1'b0;
      prio           <= 1'b0;
      rate_q         <= '0;
      len_q          <= '0;
      bit_cnt        <= '0;
      cnt            <= '0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done_q0        <= 1'b0;
      done_q1        <= 1'b0;
      err0           <= 1'b0;
      err1           <= 1'b0;
      phy_tx_request <= 1'b0;
      phy_rate       <= '0;
    end else begin
      phy_tx_request <= 1'b0;
      done_q0        <= 1'b0;
      done_q1        <= 1'b0;
      err0           <= 1'b0;
      err1           <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel    <= win;
            prio   <= ~win;
            gnt0   <= ~win;
            gnt1   <= win;
            rate_q <= win ? rate1 : rate0;
            len_q  <= win ? len1 : len0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (!rate_ok) begin
            err0  <= ~sel;
            err1  <= sel;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            cnt   <= '0;
            state <= GAP;
          end else if (len_q == '0) begin
            done_q0 <= ~sel;
            done_q1 <= sel;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            cnt     <= '0;
            state   <= GAP;
          end else begin
            phy_tx_request <= 1'b1;
            phy_rate       <= rate_q;
            state          <= REQ;
          end
        end
        REQ: begin
          cnt   <= '0;
          state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (phy_ready) begin
            bit_cnt <= '0;
            state   <= STREAM;
          end else if (cnt == CW'(READY_TIMEOUT - 1)) begin
            err0     <= ~sel;
            err1     <= sel;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            phy_rate <= '0;
            cnt      <= '0;
            state    <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STREAM: begin
          if (last_bit) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            phy_rate <= '0;
            cnt      <= '0;
            state    <= GAP;
          end else if (stream_go) begin
            bit_cnt <= bit_cnt + LEN_W'(1);
          end
        end
        GAP: begin
          if (cnt == CW'(IFS_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
